// File: rtl/mult_acc_stage_12.sv
// mult_acc_stage_12: sequential multiply-accumulate back end that sums one
// frame of unsigned products into a guarded accumulator.
// Optional feature macro: MAC_SATURATE_EN (clamp instead of wrap on carry).
// Ports:
//   clk, rst                   clock, async active-high reset
//   in_valid/in_ready/in_prod  product handshake from the multiplier
//   in_last                    final product of a frame (qualified by in_valid)
//   out_valid/out_ready        frame result handshake to the next stage
//   out_sum/out_terms/out_ovf  frame sum, term count, sticky overflow
module mult_acc_stage_12 #(
   parameter int WIDTH     = 12,
   parameter int GUARD     = 8,
   parameter int MAX_TERMS = 256
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [2*WIDTH-1:0]                 in_prod,
   input  logic                               in_last,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [2*WIDTH+GUARD-1:0]           out_sum,
   output logic [$clog2(MAX_TERMS+1)-1:0]     out_terms,
   output logic                               out_ovf
);

   localparam int PW = 2 * WIDTH;
   localparam int AW = PW + GUARD;
   localparam int SW = AW + 1;
   localparam int CW = $clog2(MAX_TERMS + 1);
   localparam logic [CW-1:0] TERM_MAX = CW'(MAX_TERMS);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t        state;
   logic [SW-1:0] sum_wide;
   logic          carry;
   logic [AW-1:0] acc_next;
   logic [CW-1:0] cnt_next;
   logic          close;

   // The accumulator and count live directly in the output registers; they
   // are zero in IDLE, so IDLE and ACCUM share one update path.
   always_comb begin
      sum_wide = {1'b0, out_sum} + SW'(in_prod);
      carry    = sum_wide[AW];
`ifdef MAC_SATURATE_EN
      // Once clamped, any further nonzero add carries again, so the
      // accumulator stays pinned at all ones for the rest of the frame.
      acc_next = carry ? {AW{1'b1}} : sum_wide[AW-1:0];
`else
      acc_next = sum_wide[AW-1:0];
`endif
      cnt_next = out_terms + 1'b1;
      close    = in_last || (cnt_next == TERM_MAX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_terms <= '0;
         out_ovf   <= 1'b0;
      end else begin
         unique case (state)
            IDLE, ACCUM: begin
               if (in_valid) begin
                  out_sum   <= acc_next;
                  out_terms <= cnt_next;
                  out_ovf   <= out_ovf | carry;
                  if (close) begin
                     state     <= DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  out_sum   <= '0;
                  out_terms <= '0;
                  out_ovf   <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               out_sum   <= '0;
               out_terms <= '0;
               out_ovf   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_acc_stage_12.sv
// tb_mult_acc_stage_12: directed checks of the frame accumulator,
// default build plus a small GUARD=1 / MAX_TERMS=4 instance.
module tb_mult_acc_stage_12;

   logic        clk;
   logic        rst;
   logic        in_valid, in_ready, in_last;
   logic [23:0] in_prod;
   logic        out_valid, out_ready;
   logic [31:0] out_sum;
   logic [8:0]  out_terms;
   logic        out_ovf;

   logic        s_in_valid, s_in_ready, s_in_last;
   logic [23:0] s_in_prod;
   logic        s_out_valid, s_out_ready;
   logic [24:0] s_out_sum;
   logic [2:0]  s_out_terms;
   logic        s_out_ovf;

   int total = 0;
   int bad   = 0;

   localparam logic [63:0] P_MAX = 64'd16769025;

   mult_acc_stage_12 dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_prod(in_prod), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_terms(out_terms), .out_ovf(out_ovf)
   );

   mult_acc_stage_12 #(.WIDTH(12), .GUARD(1), .MAX_TERMS(4)) sdut (
      .clk(clk), .rst(rst),
      .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_prod(s_in_prod), .in_last(s_in_last),
      .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_sum(s_out_sum), .out_terms(s_out_terms), .out_ovf(s_out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [23:0] p, input logic l);
      in_valid = 1'b1;
      in_prod  = p;
      in_last  = l;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic ssend(input logic [23:0] p, input logic l);
      s_in_valid = 1'b1;
      s_in_prod  = p;
      s_in_last  = l;
      step();
      s_in_valid = 1'b0;
      s_in_last  = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      in_valid = 1'b0; in_last = 1'b0; in_prod = '0; out_ready = 1'b0;
      s_in_valid = 1'b0; s_in_last = 1'b0; s_in_prod = '0;
      s_out_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_sum", 64'(out_sum), 64'd0);
      chk("rst_terms", 64'(out_terms), 64'd0);
      chk("rst_ovf", 64'(out_ovf), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // basic three-term frame
      out_ready = 1'b1;
      send(24'd15, 1'b0);
      send(24'd100, 1'b0);
      chk("t1_not_done", 64'(out_valid), 64'd0);
      send(24'd7, 1'b1);
      chk("t1_valid", 64'(out_valid), 64'd1);
      chk("t1_sum", 64'(out_sum), 64'd122);
      chk("t1_terms", 64'(out_terms), 64'd3);
      chk("t1_ovf", 64'(out_ovf), 64'd0);
      chk("t1_in_ready", 64'(in_ready), 64'd0);
      step();
      chk("t1_valid_drop", 64'(out_valid), 64'd0);
      chk("t1_ready_back", 64'(in_ready), 64'd1);

      // full MAX_TERMS frame with no in_last
      out_ready = 1'b0;
      for (int i = 0; i < 255; i++) send(24'(P_MAX), 1'b0);
      chk("t2_255_open", 64'(out_valid), 64'd0);
      chk("t2_255_terms", 64'(out_terms), 64'd255);
      send(24'(P_MAX), 1'b0);
      chk("t2_valid", 64'(out_valid), 64'd1);
      chk("t2_sum", 64'(out_sum), 64'd4292870400);
      chk("t2_terms", 64'(out_terms), 64'd256);
      chk("t2_ovf", 64'(out_ovf), 64'd0);

      // stall in DONE with a product waiting
      in_valid = 1'b1; in_prod = 24'd9; in_last = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("st_in_ready", 64'(in_ready), 64'd0);
         chk("st_valid", 64'(out_valid), 64'd1);
         chk("st_sum", 64'(out_sum), 64'd4292870400);
         chk("st_terms", 64'(out_terms), 64'd256);
      end
      out_ready = 1'b1;
      step();
      chk("st_out_xfer_ready", 64'(in_ready), 64'd1);
      chk("st_out_xfer_valid", 64'(out_valid), 64'd0);
      chk("st_out_xfer_sum", 64'(out_sum), 64'd0);
      step();
      in_valid = 1'b0;
      chk("st_nine_sum", 64'(out_sum), 64'd9);
      chk("st_nine_terms", 64'(out_terms), 64'd1);
      send(24'd1, 1'b1);
      chk("st_next_valid", 64'(out_valid), 64'd1);
      chk("st_next_sum", 64'(out_sum), 64'd10);
      chk("st_next_terms", 64'(out_terms), 64'd2);
      step();

      // single-term frame
      send(24'd42, 1'b1);
      chk("t1t_valid", 64'(out_valid), 64'd1);
      chk("t1t_sum", 64'(out_sum), 64'd42);
      chk("t1t_terms", 64'(out_terms), 64'd1);
      step();

      // asynchronous reset mid-frame
      send(24'd5, 1'b0);
      send(24'd6, 1'b0);
      chk("ar_pre_terms", 64'(out_terms), 64'd2);
      #2 rst = 1'b1;
      #1;
      chk("ar_in_ready", 64'(in_ready), 64'd1);
      chk("ar_valid", 64'(out_valid), 64'd0);
      chk("ar_sum", 64'(out_sum), 64'd0);
      chk("ar_terms", 64'(out_terms), 64'd0);
      chk("ar_ovf", 64'(out_ovf), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      send(24'd3, 1'b1);
      chk("ar_next_sum", 64'(out_sum), 64'd3);
      chk("ar_next_terms", 64'(out_terms), 64'd1);
      step();

      // small instance: overflow with GUARD=1
      ssend(24'(P_MAX), 1'b0);
      ssend(24'(P_MAX), 1'b0);
      ssend(24'(P_MAX), 1'b1);
      chk("ov_valid", 64'(s_out_valid), 64'd1);
      chk("ov_terms", 64'(s_out_terms), 64'd3);
      chk("ov_ovf", 64'(s_out_ovf), 64'd1);
`ifdef MAC_SATURATE_EN
      chk("ov_sum_sat", 64'(s_out_sum), 64'd33554431);
`else
      chk("ov_sum_wrap", 64'(s_out_sum), 64'd16752643);
`endif
      s_out_ready = 1'b1;
      step();
      chk("ov_ovf_clear", 64'(s_out_ovf), 64'd0);
      chk("ov_sum_clear", 64'(s_out_sum), 64'd0);

      // in_last on transfer MAX_TERMS closes the frame once
      ssend(24'd1, 1'b0);
      ssend(24'd1, 1'b0);
      ssend(24'd1, 1'b0);
      chk("mx_open", 64'(s_out_valid), 64'd0);
      ssend(24'd1, 1'b1);
      chk("mx_valid", 64'(s_out_valid), 64'd1);
      chk("mx_terms", 64'(s_out_terms), 64'd4);
      chk("mx_sum", 64'(s_out_sum), 64'd4);
      chk("mx_ovf", 64'(s_out_ovf), 64'd0);
      step();
      chk("mx_once_valid", 64'(s_out_valid), 64'd0);
      chk("mx_once_ready", 64'(s_in_ready), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
